// File: rtl/mem_line_responder.sv
// Main-memory responder for the C2 line bus: fixed-latency line reads and writes
// against an internal line store, with read data streamed one bus word per cycle.
module mem_line_responder #(
  parameter int BUS_SIZE    = 16,
  parameter int ADDR_SIZE   = 15,
  parameter int LINE_SIZE   = 16,
  parameter int MEM_LATENCY = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] mem_address,
  inout  wire  [BUS_SIZE-1:0]  mem_data,
  inout  wire  [1:0]           mem_command,
  output logic                 busy
);
  localparam int LINE_BITS = LINE_SIZE * 8;
  localparam int BEATS     = LINE_BITS / BUS_SIZE;
  localparam int LAT       = (MEM_LATENCY < BEATS + 2) ? BEATS + 2 : MEM_LATENCY;
  localparam int CNT_W     = $clog2(LAT + 1);
  localparam int BEAT_W    = $clog2(BEATS + 1);

  localparam logic [1:0] C2_RESPONSE = 2'd1;
  localparam logic [1:0] C2_READ     = 2'd2;
  localparam logic [1:0] C2_WRITE    = 2'd3;

  typedef enum logic [2:0] {
    IDLE, WR_RECV, RD_WAIT, WR_WAIT, RD_RESP, WR_RESP
  } state_t;

  state_t                        state;
  logic [ADDR_SIZE-1:0]          addr_reg;
  logic [CNT_W-1:0]              lat_cnt;
  logic [BEAT_W-1:0]             beat_cnt;
  logic [LINE_BITS-BUS_SIZE-1:0] wr_buf;
  logic [BUS_SIZE-1:0]           data_reg;
  logic                          cmd_en;
  logic                          data_en;

  logic [LINE_BITS-1:0] storage [2**ADDR_SIZE];
  logic [LINE_BITS-1:0] rd_raw;
  logic [LINE_BITS-1:0] rd_line;
  logic [LINE_BITS-1:0] wr_line;
  logic [LINE_BITS-1:0] pattern;
  logic                 mem_we;
  logic                 mem_re;

  assign mem_command = cmd_en  ? C2_RESPONSE : 2'bz;
  assign mem_data    = data_en ? data_reg    : {BUS_SIZE{1'bz}};

  // Power-on byte pattern of the addressed line: (line*LINE_SIZE + offset) mod 256.
  for (genvar gi = 0; gi < LINE_SIZE; gi++) begin : g_pattern
    assign pattern[8*gi +: 8] = 8'(32'(addr_reg) * LINE_SIZE + gi);
  end

  // The store keeps each line XOR its power-on pattern, so a zero-initialised
  // array reads back as the required initial content without any init pass.
  assign mem_we  = (state == WR_RECV) && (beat_cnt == BEAT_W'(BEATS - 1));
  assign mem_re  = (state == RD_WAIT) && (lat_cnt == CNT_W'(LAT - 1));
  assign wr_line = {mem_data, wr_buf};
  assign rd_line = rd_raw ^ pattern;

  always_ff @(posedge clk) begin
    if (mem_we) storage[addr_reg] <= wr_line ^ pattern;
    if (mem_re) rd_raw <= storage[addr_reg];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_reg <= '0;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      wr_buf   <= '0;
      data_reg <= '0;
      cmd_en   <= 1'b0;
      data_en  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_command == C2_READ) begin
            addr_reg <= mem_address;
            lat_cnt  <= CNT_W'(1);
            busy     <= 1'b1;
            state    <= RD_WAIT;
          end else if (mem_command == C2_WRITE) begin
            addr_reg             <= mem_address;
            wr_buf[BUS_SIZE-1:0] <= mem_data;
            beat_cnt             <= BEAT_W'(1);
            lat_cnt              <= CNT_W'(1);
            busy                 <= 1'b1;
            state                <= WR_RECV;
          end
        end
        WR_RECV: begin
          lat_cnt <= lat_cnt + CNT_W'(1);
          if (beat_cnt == BEAT_W'(BEATS - 1)) begin
            beat_cnt <= '0;
            state    <= WR_WAIT;
          end else begin
            wr_buf[BUS_SIZE*beat_cnt +: BUS_SIZE] <= mem_data;
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (lat_cnt == CNT_W'(LAT)) begin
            cmd_en <= 1'b1;
            if (state == RD_WAIT) begin
              data_en  <= 1'b1;
              data_reg <= rd_line[BUS_SIZE-1:0];
              beat_cnt <= BEAT_W'(1);
              state    <= RD_RESP;
            end else begin
              state <= WR_RESP;
            end
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        RD_RESP: begin
          if (beat_cnt == BEAT_W'(BEATS)) begin
            cmd_en   <= 1'b0;
            data_en  <= 1'b0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            state    <= IDLE;
          end else begin
            data_reg <= rd_line[BUS_SIZE*beat_cnt +: BUS_SIZE];
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        WR_RESP: begin
          cmd_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: table of directed line transactions, hand-built
// reset/ignore/latency-floor corners, then random traffic against a line-array model.
module tb_mem_line_responder;
  localparam int BEATS = 8;
  localparam logic [1:0] C2_READ  = 2'd2;
  localparam logic [1:0] C2_WRITE = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [14:0] tb_addr = '0;
  logic [1:0]  tb_cmd = '0;
  logic [15:0] tb_data = '0;
  logic        tb_cmd_en = 1'b0;
  logic        tb_data_en = 1'b0;
  logic        sel = 1'b0;

  wire [15:0] mem_data;
  wire [1:0]  mem_command;
  logic       busy;
  wire [15:0] f_data;
  wire [1:0]  f_command;
  logic       f_busy;

  assign mem_command = (tb_cmd_en && !sel)  ? tb_cmd  : 2'bz;
  assign mem_data    = (tb_data_en && !sel) ? tb_data : 16'bz;
  assign f_command   = (tb_cmd_en && sel)   ? tb_cmd  : 2'bz;
  assign f_data      = (tb_data_en && sel)  ? tb_data : 16'bz;

  wire [1:0]  obs_cmd  = sel ? f_command : mem_command;
  wire [15:0] obs_data = sel ? f_data : mem_data;
  wire        obs_busy = sel ? f_busy : busy;

  mem_line_responder #(.MEM_LATENCY(100)) dut (
    .clk(clk), .reset(reset), .mem_address(tb_addr),
    .mem_data(mem_data), .mem_command(mem_command), .busy(busy)
  );

  mem_line_responder #(.MEM_LATENCY(3)) dut_fast (
    .clk(clk), .reset(reset), .mem_address(tb_addr),
    .mem_data(f_data), .mem_command(f_command), .busy(f_busy)
  );

  int tests = 0;
  int errors = 0;

  typedef struct {
    bit           fast;
    bit           wr;
    logic [14:0]  addr;
    logic [127:0] wline;
    logic [127:0] exp_line;
    int           lat;
    int           inject_j;
    int           abort_j;
  } txn_t;

  txn_t tbl[$];
  logic [127:0] model [int];

  function automatic txn_t mk(input bit fast, input bit wr, input logic [14:0] addr,
                              input logic [127:0] wline, input logic [127:0] exp_line,
                              input int lat, input int inject_j, input int abort_j);
    txn_t t;
    t.fast = fast; t.wr = wr; t.addr = addr; t.wline = wline; t.exp_line = exp_line;
    t.lat = lat; t.inject_j = inject_j; t.abort_j = abort_j;
    return t;
  endfunction

  function automatic logic [127:0] pattern_line(input int line);
    logic [127:0] r;
    r = '0;
    for (int o = 0; o < 16; o++) r[8*o +: 8] = 8'((line * 16 + o) % 256);
    return r;
  endfunction

  task automatic chk(input string name, input int j, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @T0+%0d: got %h, want %h", name, j, act, exp);
    end
  endtask

  // A released bus reads as z in a 4-state simulator and as 0 in a 2-state one.
  task automatic chk_rel(input string name, input int j, input logic [15:0] act);
    tests++;
    if (!($isunknown(act) || act == 16'h0)) begin
      errors++;
      $display("FAIL %s @T0+%0d: got %h, want released bus", name, j, act);
    end
  endtask

  task automatic do_txn(input int idx, input txn_t t);
    int e0;
    int last;
    bit in_resp;
    e0 = errors;
    last = t.wr ? t.lat + 1 : t.lat + BEATS;
    @(negedge clk);
    sel = t.fast; tb_addr = t.addr; tb_cmd = t.wr ? C2_WRITE : C2_READ; tb_cmd_en = 1'b1;
    tb_data = t.wline[15:0]; tb_data_en = t.wr;
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      if (j == 0) tb_cmd_en = 1'b0;
      if (t.wr && j < BEATS - 1) tb_data = t.wline[16*(j+1) +: 16];
      if (t.wr && j == BEATS - 1) tb_data_en = 1'b0;
      if (t.inject_j >= 0 && j == t.inject_j) begin
        tb_cmd = C2_WRITE; tb_addr = 15'h0003; tb_data = 16'hDEAD;
        tb_cmd_en = 1'b1; tb_data_en = 1'b1;
      end
      if (t.inject_j >= 0 && j == t.inject_j + 1) begin
        tb_cmd_en = 1'b0; tb_data_en = 1'b0;
      end
      #1;
      chk("busy", j, {15'h0, obs_busy}, {15'h0, (j <= last - 1)});
      if (!(t.inject_j >= 0 && j == t.inject_j)) begin
        in_resp = t.wr ? (j == t.lat) : (j >= t.lat && j < t.lat + BEATS);
        if (in_resp) chk("cmd", j, {14'h0, obs_cmd}, 16'h0001);
        else chk_rel("cmd", j, {14'h0, obs_cmd});
        if (!t.wr && in_resp) chk("beat", j, obs_data, t.exp_line[16*(j-t.lat) +: 16]);
        else if (!t.wr || j >= BEATS - 1) chk_rel("data", j, obs_data);
      end
      if (j == t.abort_j) begin
        tb_cmd_en = 1'b0; tb_data_en = 1'b0;
        reset = 1'b1;
        #1;
        chk_rel("rst_cmd", j, {14'h0, obs_cmd});
        chk_rel("rst_data", j, obs_data);
        chk("rst_busy", j, {15'h0, obs_busy}, 16'h0);
        reset = 1'b0;
        break;
      end
    end
    $display("[TB] txn %0d %s %s addr=%h lat=%0d errors=%0d", idx, t.fast ? "fast" : "main",
             t.wr ? "WRITE" : "READ ", t.addr, t.lat, errors - e0);
  endtask

  localparam logic [127:0] P3  = 128'h3F3E3D3C3B3A39383736353433323130;
  localparam logic [127:0] P7  = 128'h7F7E7D7C7B7A79787776757473727170;
  localparam logic [127:0] P10 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] P5  = 128'h5F5E5D5C5B5A59585756555453525150;
  localparam logic [127:0] PFF = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
  localparam logic [127:0] D1  = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
  localparam logic [127:0] D2  = 128'hCAFE_BABE_1357_2468_0F0F_F0F0_A5A5_5A5A;
  localparam logic [127:0] D3  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  initial begin
    bit           wr;
    logic [14:0]  a;
    logic [127:0] w;
    logic [127:0] e;
    txn_t         t;

    tbl.push_back(mk(0, 0, 15'h0003, '0,  P3,  100, -1,  -1));
    tbl.push_back(mk(0, 1, 15'h1234, D1,  '0,  100, -1,  -1));
    tbl.push_back(mk(0, 0, 15'h1234, '0,  D1,  100, -1,  -1));
    tbl.push_back(mk(0, 0, 15'h0007, '0,  P7,  100,  4,  -1));
    tbl.push_back(mk(0, 0, 15'h0003, '0,  P3,  100, -1,  -1));
    tbl.push_back(mk(0, 0, 15'h0003, '0,  P3,  100, -1, 103));
    tbl.push_back(mk(0, 0, 15'h0003, '0,  P3,  100, -1,  -1));
    tbl.push_back(mk(0, 1, 15'h0010, D2,  '0,  100, -1,   4));
    tbl.push_back(mk(0, 0, 15'h0010, '0,  P10, 100, -1,  -1));
    tbl.push_back(mk(0, 0, 15'h7FFF, '0,  PFF, 100, -1,  -1));
    tbl.push_back(mk(0, 1, 15'h7FFF, D2,  '0,  100, -1,  -1));
    tbl.push_back(mk(0, 0, 15'h7FFF, '0,  D2,  100, -1,  -1));
    tbl.push_back(mk(1, 0, 15'h0005, '0,  P5,  10,  -1,  -1));
    tbl.push_back(mk(1, 1, 15'h0001, D3,  '0,  10,  -1,  -1));
    tbl.push_back(mk(1, 0, 15'h0001, '0,  D3,  10,  -1,  -1));

    #12;
    chk("reset_busy", 0, {15'h0, busy}, 16'h0);
    chk_rel("reset_cmd", 0, {14'h0, mem_command});
    chk_rel("reset_data", 0, mem_data);
    chk("reset_fbusy", 0, {15'h0, f_busy}, 16'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) do_txn(i, tbl[i]);

    for (int n = 0; n < 20; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 15'h0020 + 15'($urandom_range(0, 3));
      w  = {$urandom, $urandom, $urandom, $urandom};
      e  = model.exists(int'(a)) ? model[int'(a)] : pattern_line(int'(a));
      t  = mk(0, wr, a, w, e, 100, -1, -1);
      do_txn(100 + n, t);
      if (wr) model[int'(a)] = w;
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
